// File: rtl/proc_pkg.sv
// Shared ISA and controller definitions for the programmable processor.
package proc_pkg;

    localparam int unsigned IR_W  = 16;
    localparam int unsigned ST_W  = 4;
    localparam int unsigned ALU_W = 3;

    // Instruction register field slices
    localparam int unsigned IR_OP_HI = 15;
    localparam int unsigned IR_OP_LO = 12;
    localparam int unsigned IR_DA_HI = 11;
    localparam int unsigned IR_DA_LO = 4;
    localparam int unsigned IR_RA_HI = 11;
    localparam int unsigned IR_RA_LO = 8;
    localparam int unsigned IR_RB_HI = 7;
    localparam int unsigned IR_RB_LO = 4;
    localparam int unsigned IR_RD_HI = 3;
    localparam int unsigned IR_RD_LO = 0;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd2;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_t;

    typedef enum logic [ST_W-1:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOADA  = 4'd4,
        ST_LOADB  = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

endpackage

// File: rtl/control_unit_if.sv
// Controller-to-datapath strobe bundle; the controller is the master side.
interface control_unit_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8,
    parameter int unsigned RW = 4
);
    logic [DW-1:0]              IR;
    logic                       PC_Clr;
    logic                       PC_Up;
    logic                       IR_Ld;
    logic [AW-1:0]              D_Addr;
    logic                       D_Wr;
    logic                       RF_s;
    logic [RW-1:0]              RF_W_Addr;
    logic                       RF_W_En;
    logic [RW-1:0]              RF_Ra_Addr;
    logic [RW-1:0]              RF_Rb_Addr;
    logic [proc_pkg::ALU_W-1:0] ALU_s0;
    logic [proc_pkg::ST_W-1:0]  OutState;

    modport master (
        input  IR,
        output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, OutState
    );

    modport slave (
        output IR,
        input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, OutState
    );
endinterface

// File: rtl/control_decode.sv
// Moore output decode: strobes depend only on the current state and the IR operand fields.
module control_decode
    import proc_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned RW = 4
) (
    input  state_t             state,
    input  logic [IR_DA_HI:0]  ir_operand,
    output logic               pc_clr,
    output logic               pc_up,
    output logic               ir_ld,
    output logic [AW-1:0]      d_addr,
    output logic               d_wr,
    output logic               rf_s,
    output logic [RW-1:0]      rf_w_addr,
    output logic               rf_w_en,
    output logic [RW-1:0]      rf_ra_addr,
    output logic [RW-1:0]      rf_rb_addr,
    output logic [ALU_W-1:0]   alu_s0
);

    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = '0;
        case (state)
            ST_INIT:  pc_clr = 1'b1;
            ST_FETCH: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
            end
            // LoadA only covers the synchronous memory read latency; LoadB commits
            ST_LOADA, ST_LOADB: begin
                d_addr    = AW'(ir_operand[IR_DA_HI:IR_DA_LO]);
                rf_s      = 1'b1;
                rf_w_addr = RW'(ir_operand[IR_RD_HI:IR_RD_LO]);
                rf_w_en   = (state == ST_LOADB);
            end
            ST_STORE: begin
                d_addr     = AW'(ir_operand[IR_DA_HI:IR_DA_LO]);
                rf_ra_addr = RW'(ir_operand[IR_RD_HI:IR_RD_LO]);
                d_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                rf_ra_addr = RW'(ir_operand[IR_RA_HI:IR_RA_LO]);
                rf_rb_addr = RW'(ir_operand[IR_RB_HI:IR_RB_LO]);
                rf_w_addr  = RW'(ir_operand[IR_RD_HI:IR_RD_LO]);
                rf_w_en    = 1'b1;
                alu_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer: state register and next-state logic; strobes come from control_decode.
module control_unit
    import proc_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8,
    parameter int unsigned RW = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    control_unit_if.master bus
);

    state_t              state_q;
    state_t              state_d;
    logic [DW-1:0]       ir;
    logic [3:0]          opcode;

    assign ir     = bus.IR;
    assign opcode = ir[IR_OP_HI:IR_OP_LO];

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // Undefined opcodes execute as NOOP; illegal state encodings fall back to Init
    always_comb begin
        state_d = ST_INIT;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD:  state_d = ST_LOADA;
                    OP_STORE: state_d = ST_STORE;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_NOOP:   state_d = ST_FETCH;
            ST_LOADA:  state_d = ST_LOADB;
            ST_LOADB:  state_d = ST_FETCH;
            ST_STORE:  state_d = ST_FETCH;
            ST_ADD:    state_d = ST_FETCH;
            ST_SUB:    state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    assign bus.OutState = ST_W'(state_q);

    control_decode #(
        .AW (AW),
        .RW (RW)
    ) u_decode (
        .state      (state_q),
        .ir_operand (ir[IR_DA_HI:0]),
        .pc_clr     (bus.PC_Clr),
        .pc_up      (bus.PC_Up),
        .ir_ld      (bus.IR_Ld),
        .d_addr     (bus.D_Addr),
        .d_wr       (bus.D_Wr),
        .rf_s       (bus.RF_s),
        .rf_w_addr  (bus.RF_W_Addr),
        .rf_w_en    (bus.RF_W_En),
        .rf_ra_addr (bus.RF_Ra_Addr),
        .rf_rb_addr (bus.RF_Rb_Addr),
        .alu_s0     (bus.ALU_s0)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks every instruction class, reset overrides and Halt.
module tb_control_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    control_unit_if #(.DW(16), .AW(8), .RW(4)) bus ();

    control_unit #(.DW(16), .AW(8), .RW(4)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected state plus every strobe; strobes packed {pc_clr,pc_up,ir_ld,d_addr,d_wr,rf_s,wa,wen,ra,rb,alu}
    task automatic expect_out(input string tag, input logic [3:0] st,
                              input logic pc_clr, input logic pc_up, input logic ir_ld,
                              input logic [7:0] d_addr, input logic d_wr, input logic rf_s,
                              input logic [3:0] wa, input logic wen,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu);
        logic [31:0] got_v;
        logic [31:0] exp_v;
        got_v = {3'b0, bus.PC_Clr, bus.PC_Up, bus.IR_Ld, bus.D_Addr, bus.D_Wr, bus.RF_s,
                 bus.RF_W_Addr, bus.RF_W_En, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.ALU_s0};
        exp_v = {3'b0, pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, wa, wen, ra, rb, alu};
        check({tag, ".state"}, 32'(bus.OutState), 32'(st));
        check({tag, ".outs"}, got_v, exp_v);
        check({tag, ".wr_excl"}, 32'(bus.D_Wr & bus.RF_W_En), 32'd0);
    endtask

    task automatic expect_idle(input string tag, input logic [3:0] st);
        expect_out(tag, st, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0);
    endtask

    task automatic expect_fetch(input string tag);
        expect_out(tag, 4'd1, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        bus.IR   = 16'h0000;

        tick();
        expect_out("rst1", 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0);
        tick();
        expect_out("rst2", 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0);
        rst = 1'b0;
        tick();
        expect_fetch("fetch0");

        // LOAD R5 <- D[A3]
        bus.IR = 16'h1A35;
        tick(); expect_idle("ld.decode", 4'd2);
        tick(); expect_out("ld.a", 4'd4, 0, 0, 0, 8'hA3, 0, 1, 4'h5, 0, 4'h0, 4'h0, 3'd0);
        tick(); expect_out("ld.b", 4'd5, 0, 0, 0, 8'hA3, 0, 1, 4'h5, 1, 4'h0, 4'h0, 3'd0);
        tick(); expect_fetch("ld.fetch");

        // STORE D[F0] <- R7
        bus.IR = 16'h2F07;
        tick(); expect_idle("st.decode", 4'd2);
        tick(); expect_out("st.exec", 4'd6, 0, 0, 0, 8'hF0, 1, 0, 4'h0, 0, 4'h7, 4'h0, 3'd0);
        tick(); expect_fetch("st.fetch");

        // ADD R4 <- R1 + R2
        bus.IR = 16'h3124;
        tick(); expect_idle("add.decode", 4'd2);
        tick(); expect_out("add.exec", 4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h4, 1, 4'h1, 4'h2, 3'd1);
        tick(); expect_fetch("add.fetch");

        // SUB R4 <- R1 - R2
        bus.IR = 16'h4124;
        tick(); expect_idle("sub.decode", 4'd2);
        tick(); expect_out("sub.exec", 4'd8, 0, 0, 0, 8'h00, 0, 0, 4'h4, 1, 4'h1, 4'h2, 3'd2);
        tick(); expect_fetch("sub.fetch");

        // Undefined opcode executes as NOOP
        bus.IR = 16'hE000;
        tick(); expect_idle("undef.decode", 4'd2);
        tick(); expect_idle("undef.noop", 4'd3);
        tick(); expect_fetch("undef.fetch");

        // Reset taken in LoadA: no register write on the way out
        bus.IR = 16'h1A35;
        tick(); expect_idle("ldrst.decode", 4'd2);
        tick(); expect_out("ldrst.a", 4'd4, 0, 0, 0, 8'hA3, 0, 1, 4'h5, 0, 4'h0, 4'h0, 3'd0);
        rst = 1'b1;
        tick(); expect_out("ldrst.init", 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0);
        rst = 1'b0;
        tick(); expect_fetch("ldrst.fetch");

        // HALT holds regardless of IR until reset
        bus.IR = 16'h5000;
        tick(); expect_idle("halt.decode", 4'd2);
        tick(); expect_idle("halt.enter", 4'd9);
        bus.IR = 16'h3124;
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_idle($sformatf("halt.hold%0d", i), 4'd9);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("halt.rst%0d", i), 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0);
        end
        rst = 1'b0;
        tick(); expect_fetch("post.fetch");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
